// File: rtl/seg7_pkg.sv
// Shared 7-segment constants: segment bit order, the 16 hex glyphs and the blank glyph.
// Both the display encoder and the frame decoder import this package.
package seg7_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h1F;
  localparam logic [6:0] SEG_HEX_C = 7'h4E;
  localparam logic [6:0] SEG_HEX_D = 7'h3D;
  localparam logic [6:0] SEG_HEX_E = 7'h4F;
  localparam logic [6:0] SEG_HEX_F = 7'h47;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int DEFAULT_STABLE_CYCLES = 4;

  typedef struct packed {
    logic [3:0] nibble;
    logic       blank;
    logic       bad;
  } seg7_dec_t;

endpackage

// File: rtl/seg7_pattern_lut.sv
// Combinational inverse of the 7-segment encoder: glyph -> {nibble, blank, bad}.
module seg7_pattern_lut
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output seg7_dec_t  dec
);

  always_comb begin
    dec = '{nibble: 4'h0, blank: 1'b0, bad: 1'b0};
    case (seg)
      SEG_0:     dec.nibble = 4'h0;
      SEG_1:     dec.nibble = 4'h1;
      SEG_2:     dec.nibble = 4'h2;
      SEG_3:     dec.nibble = 4'h3;
      SEG_4:     dec.nibble = 4'h4;
      SEG_5:     dec.nibble = 4'h5;
      SEG_6:     dec.nibble = 4'h6;
      SEG_7:     dec.nibble = 4'h7;
      SEG_8:     dec.nibble = 4'h8;
      SEG_9:     dec.nibble = 4'h9;
      SEG_HEX_A: dec.nibble = 4'hA;
      SEG_HEX_B: dec.nibble = 4'hB;
      SEG_HEX_C: dec.nibble = 4'hC;
      SEG_HEX_D: dec.nibble = 4'hD;
      SEG_HEX_E: dec.nibble = 4'hE;
      SEG_HEX_F: dec.nibble = 4'hF;
      SEG_BLANK: dec.blank  = 1'b1;
      default:   dec.bad    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Snoops a multiplexed 7-segment bus, debounces each digit dwell and rebuilds the full frame.
// valid: single-cycle strobe, no backpressure; value/blank/err are stable whenever valid is high and hold until the next strobe.
module seg7_frame_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     sel,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     blank,
  output logic                  valid,
  output logic                  err
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [6:0]            seg_q;
  logic [DIGITS-1:0]     sel_q;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  accepted, acc_eff;
  logic                  changed, onehot, accept, complete;
  logic [6:0]            seg_src;
  seg7_dec_t             dec;

  logic [DIGITS-1:0]        mask, mask_nxt;
  logic [DIGITS-1:0][3:0]   slot_nib, nib_nxt;
  logic [DIGITS-1:0]        slot_blank, blank_nxt;
  logic [DIGITS-1:0]        slot_bad, bad_nxt;

  // With a single-sample filter the accept edge is also the reload edge, so decode the live bus.
  assign seg_src = (STABLE_CYCLES == 1) ? seg : seg_q;

  seg7_pattern_lut u_lut (
    .seg (seg_src),
    .dec (dec)
  );

  always_comb begin
    changed  = (seg != seg_q) || (sel != sel_q);
    cnt_nxt  = changed ? '0 : ((cnt == CNT_MAX) ? cnt : cnt + 1'b1);
    acc_eff  = changed ? 1'b0 : accepted;
    onehot   = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    accept   = onehot && !acc_eff && (cnt_nxt == CNT_MAX);
    mask_nxt = accept ? (mask | sel) : mask;
    complete = accept && (&mask_nxt);
    nib_nxt   = slot_nib;
    blank_nxt = slot_blank;
    bad_nxt   = slot_bad;
    for (int i = 0; i < DIGITS; i++) begin
      if (accept && sel[i]) begin
        nib_nxt[i]   = dec.nibble;
        blank_nxt[i] = dec.blank;
        bad_nxt[i]   = dec.bad;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q      <= '0;
      sel_q      <= '0;
      cnt        <= '0;
      accepted   <= 1'b0;
      mask       <= '0;
      slot_nib   <= '0;
      slot_blank <= '0;
      slot_bad   <= '0;
      value      <= '0;
      blank      <= '0;
      valid      <= 1'b0;
      err        <= 1'b0;
    end else begin
      seg_q      <= seg;
      sel_q      <= sel;
      cnt        <= cnt_nxt;
      accepted   <= accept | acc_eff;
      mask       <= complete ? '0 : mask_nxt;
      slot_nib   <= nib_nxt;
      slot_blank <= blank_nxt;
      slot_bad   <= bad_nxt;
      valid      <= complete;
      if (complete) begin
        value <= nib_nxt;
        blank <= blank_nxt;
        err   <= |bad_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Scoreboard bench for seg7_frame_decoder: directed digit sweeps with hand-computed frames.
module tb_seg7_frame_decoder;

  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS + DIGITS + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [6:0]          seg = '0;
  logic [DIGITS-1:0]   sel = '0;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   blank;
  logic                valid;
  logic                err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];

  seg7_frame_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .seg   (seg),
    .sel   (sel),
    .value (value),
    .blank (blank),
    .valid (valid),
    .err   (err)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // driver tasks; all called and returning on a falling edge
  task automatic do_reset();
    rst = 1'b1;
    seg = '0;
    sel = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
    seg = s;
    sel = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [15:0] v, input logic [3:0] b, input logic e);
    exp_q.push_back({v, b, e});
    exp_cyc_q.push_back(cyc);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_value"}, 32'(value), 32'h0);
    check({tag, "_blank"}, 32'(blank), 32'h0);
    check({tag, "_err"},   32'(err),   32'h0);
    check({tag, "_valid"}, 32'(valid), 32'h0);
  endtask

  // monitor: pops an expectation on every valid strobe
  always @(negedge clk) begin
    #1;
    if (!rst && valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got valid=1 expected no frame (cycle %0d)", cyc);
      end else begin
        logic [W-1:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("frame_value", 32'(value), 32'(e[W-1:DIGITS+1]));
        check("frame_blank", 32'(blank), 32'(e[DIGITS:1]));
        check("frame_err",   32'(err),   32'(e[0]));
        check("frame_cycle", 32'(cyc),   32'(ec));
      end
    end
  end

  initial begin
    @(negedge clk);
    do_reset();
    check_idle_outputs("reset");

    // 1: basic sweep
    hold(7'h7E, 4'b0001, 4);
    hold(7'h30, 4'b0010, 4);
    hold(7'h6D, 4'b0100, 4);
    hold(7'h79, 4'b1000, 4);
    push_exp(16'h3210, 4'b0000, 1'b0);
    hold(7'h00, 4'b0000, 3);

    // 2: digit 2 too short in the first sweep; second sweep completes at digit 2
    do_reset();
    hold(7'h7E, 4'b0001, 4);
    hold(7'h30, 4'b0010, 4);
    hold(7'h6D, 4'b0100, 3);
    hold(7'h79, 4'b1000, 4);
    hold(7'h7E, 4'b0001, 4);
    hold(7'h30, 4'b0010, 4);
    hold(7'h6D, 4'b0100, 4);
    push_exp(16'h3210, 4'b0000, 1'b0);
    hold(7'h79, 4'b1000, 4);

    // 3: blank digit, then a bad glyph, then a clean frame
    do_reset();
    hold(7'h00, 4'b0001, 4);
    hold(7'h4E, 4'b0010, 4);
    hold(7'h1F, 4'b0100, 4);
    hold(7'h77, 4'b1000, 4);
    push_exp(16'hABC0, 4'b0001, 1'b0);
    hold(7'h00, 4'b0001, 4);
    hold(7'h01, 4'b0010, 4);
    hold(7'h1F, 4'b0100, 4);
    hold(7'h77, 4'b1000, 4);
    push_exp(16'hAB00, 4'b0001, 1'b1);
    hold(7'h7E, 4'b0001, 4);
    hold(7'h30, 4'b0010, 4);
    hold(7'h6D, 4'b0100, 4);
    hold(7'h79, 4'b1000, 4);
    push_exp(16'h3210, 4'b0000, 1'b0);
    hold(7'h00, 4'b0000, 3);

    // 4: long dwell on digit 0 is captured once
    do_reset();
    hold(7'h7F, 4'b0001, 20);
    hold(7'h30, 4'b0010, 4);
    hold(7'h6D, 4'b0100, 4);
    hold(7'h79, 4'b1000, 4);
    push_exp(16'h3218, 4'b0000, 1'b0);
    hold(7'h00, 4'b0000, 3);

    // 5: multi-hot select ignored
    do_reset();
    hold(7'h7E, 4'b0011, 10);
    hold(7'h5B, 4'b0001, 4);
    hold(7'h30, 4'b0010, 4);
    hold(7'h6D, 4'b0100, 4);
    hold(7'h79, 4'b1000, 4);
    push_exp(16'h3215, 4'b0000, 1'b0);
    hold(7'h00, 4'b0000, 3);

    // 6: reset mid-frame discards digits 0-2
    do_reset();
    hold(7'h7E, 4'b0001, 4);
    hold(7'h30, 4'b0010, 4);
    hold(7'h6D, 4'b0100, 4);
    do_reset();
    hold(7'h79, 4'b1000, 6);
    check_idle_outputs("after_reset_midframe");
    hold(7'h4F, 4'b0001, 4);
    hold(7'h47, 4'b0010, 4);
    hold(7'h5F, 4'b0100, 4);
    push_exp(16'h36FE, 4'b0000, 1'b0);
    hold(7'h00, 4'b0000, 4);

    check("leftover_expected", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
